// File: rtl/fill_pkg.sv
// Shared definitions for the fill-datapath line responder: parameter defaults,
// responder state encoding and a counter-width helper.
package fill_pkg;

  localparam int ADDR_SIZE_BITS_DEF  = 16;
  localparam int WORD_SIZE_BYTES_DEF = 3;
  localparam int DATA_SIZE_WORDS_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_READ_TAIL,
    ST_WRITE,
    ST_DONE
  } fill_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Word index for one line transfer: counts 0..N-1, wraps to 0 after the
// terminal count, and can be cleared between transfers.
module fill_word_counter
  import fill_pkg::*;
#(
  parameter  int N  = DATA_SIZE_WORDS_DEF,
  localparam int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q, count_d;

  assign tc_o    = (count_q == CW'(N - 1));
  assign count_o = count_q;

  // NOTE: the default assignment first means every path drives count_d, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + CW'(1);
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fill_mem_responder.sv
// Moves one pixel line between the fill datapath and a single-word SRAM,
// one word per cycle, with a one-cycle SRAM read latency.
module fill_mem_responder
  import fill_pkg::*;
#(
  parameter int ADDR_SIZE_BITS  = ADDR_SIZE_BITS_DEF,
  parameter int WORD_SIZE_BYTES = WORD_SIZE_BYTES_DEF,
  parameter int DATA_SIZE_WORDS = DATA_SIZE_WORDS_DEF
) (
  input  logic                                          clk,
  input  logic                                          n_rst,
  input  logic                                          read_enable,
  input  logic                                          write_enable,
  input  logic [ADDR_SIZE_BITS-1:0]                     address,
  input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0]  write_data,
  output logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0]  read_data,
  output logic                                          busy,
  output logic                                          req_done,
  output logic                                          req_err,
  output logic [ADDR_SIZE_BITS-1:0]                     mem_addr,
  output logic                                          mem_re,
  output logic                                          mem_we,
  output logic [WORD_SIZE_BYTES*8-1:0]                  mem_wdata,
  input  logic [WORD_SIZE_BYTES*8-1:0]                  mem_rdata
);

  localparam int WORD_BITS = WORD_SIZE_BYTES * 8;
  localparam int LINE_BITS = WORD_BITS * DATA_SIZE_WORDS;
  localparam int CW        = cnt_width(DATA_SIZE_WORDS);
  localparam int LAST      = DATA_SIZE_WORDS - 1;

  fill_state_e                state_q, state_d;
  logic [ADDR_SIZE_BITS-1:0]  base_q, base_d;
  logic [LINE_BITS-1:0]       wdata_q, wdata_d;
  logic [LINE_BITS-1:0]       rdata_q, rdata_d;
  logic                       err_q, err_d;
  logic                       cnt_clr, cnt_en, last_word;
  logic [CW-1:0]              word_idx;

  fill_word_counter #(.N(DATA_SIZE_WORDS)) u_word_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (word_idx),
    .tc_o    (last_word)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (read_enable && write_enable) begin
          err_d = 1'b1;
        end else if (read_enable) begin
          state_d = ST_READ;
          base_d  = address;
        end else if (write_enable) begin
          state_d = ST_WRITE;
          base_d  = address;
          wdata_d = write_data;
        end
      end
      ST_READ: begin
        cnt_en = 1'b1;
        if (last_word) state_d = ST_READ_TAIL;
      end
      // The last word's SRAM data arrives one cycle after its strobe.
      ST_READ_TAIL: state_d = ST_DONE;
      ST_WRITE: begin
        cnt_en = 1'b1;
        if (last_word) state_d = ST_DONE;
      end
      ST_DONE: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // mem_rdata holds the word strobed in the previous cycle, i.e. index word_idx-1.
  always_comb begin
    rdata_d = rdata_q;
    if (state_q == ST_READ_TAIL) begin
      rdata_d[LAST*WORD_BITS +: WORD_BITS] = mem_rdata;
    end else if (state_q == ST_READ && word_idx != '0) begin
      rdata_d[(int'(word_idx) - 1)*WORD_BITS +: WORD_BITS] = mem_rdata;
    end
  end

  // NOTE: the line registers are plain flops, not a RAM, so they take reset to give defined outputs.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign req_done  = (state_q == ST_DONE);
  assign req_err   = err_q;
  assign mem_re    = (state_q == ST_READ);
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = base_q + ADDR_SIZE_BITS'(word_idx);
  assign mem_wdata = wdata_q[int'(word_idx)*WORD_BITS +: WORD_BITS];
  assign read_data = rdata_q;

endmodule

// File: doc/fill_mem_responder.md
FILL_MEM_RESPONDER -- requirements
Module: fill_mem_responder

Interface
REQ-001 Parameter ADDR_SIZE_BITS, default 16: word-address width of the request and SRAM ports.
REQ-002 Parameter WORD_SIZE_BYTES, default 3: bytes per pixel word (24 bits).
REQ-003 Parameter DATA_SIZE_WORDS, default 64: words per line transfer; line width is 1536 bits at defaults.
REQ-004 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-005 n_rst  input  1  synchronous, active-high reset: when n_rst=1 at a rising edge, the block resets; it is not active-low despite the name.
REQ-006 read_enable  input  1  line-read request from the fill datapath, sampled in IDLE.
REQ-007 write_enable  input  1  line-write request, sampled in IDLE.
REQ-008 address  input  ADDR_SIZE_BITS  word address of line word 0.
REQ-009 write_data  input  WORD_SIZE_BYTES*DATA_SIZE_WORDS*8  line to write; word i occupies bits [24i+23:24i].
REQ-010 read_data  output  same width  last line read, same word packing.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 req_done  output  1  one-cycle pulse when a transfer completes.
REQ-013 req_err  output  1  one-cycle pulse for an illegal request.
REQ-014 mem_addr  output  ADDR_SIZE_BITS  single-word SRAM address.
REQ-015 mem_re / mem_we  output  1 each  SRAM read / write strobes.
REQ-016 mem_wdata  output  24  SRAM write word; mem_rdata  input  24  SRAM read word, valid one cycle after mem_re.

Function
REQ-017 The FSM SHALL have states IDLE, READ, READ_TAIL, WRITE and DONE.
REQ-018 In IDLE, read_enable=1 with write_enable=0 SHALL latch address and move to READ; write_enable=1 with read_enable=0 SHALL latch address and write_data and move to WRITE.
REQ-019 In IDLE, both enables high SHALL pulse req_err for one cycle, SHALL stay in IDLE and SHALL issue no SRAM access.
REQ-020 Requests seen outside IDLE SHALL be ignored; latched address and data SHALL not change.
REQ-021 READ SHALL assert mem_re for exactly DATA_SIZE_WORDS consecutive cycles with mem_addr = base+i, i = 0..63, then go to READ_TAIL.
REQ-022 Word i of mem_rdata SHALL be captured into read_data word i on the edge one cycle after its mem_re cycle; READ_TAIL captures word 63 and goes to DONE.
REQ-023 WRITE SHALL assert mem_we for exactly DATA_SIZE_WORDS cycles with mem_addr = base+i and mem_wdata = latched word i, then go to DONE.
REQ-024 DONE SHALL assert req_done for one cycle and return to IDLE.
REQ-025 Latency: a read sampled at edge E0 has mem_re high in cycles 1..64 and req_done high in cycle 66; a write has mem_we high in cycles 1..64 and req_done high in cycle 65.
REQ-026 mem_addr SHALL wrap modulo 2^ADDR_SIZE_BITS, so base 0xFFF0 continues 0xFFFF, 0x0000, and so on.
REQ-027 read_data SHALL update only for words captured during a read and SHALL hold between reads; a write SHALL not alter it.
REQ-028 mem_re and mem_we SHALL never both be high; both SHALL be low outside READ and WRITE.
REQ-029 A new request MAY be accepted in the first IDLE cycle after DONE.

Reset
REQ-030 When n_rst=1 at a rising edge, the state SHALL become IDLE and the word counter 0.
REQ-031 Reset values: read_data=0, busy=0, req_done=0, req_err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset during READ or WRITE SHALL abort the transfer with no req_done; SRAM strobes SHALL be low from the cycle after that edge.

Structure
REQ-033 The shared package fill_pkg SHALL hold the parameter defaults and the responder state enum.
REQ-034 One sub-module, fill_word_counter, SHALL provide a 0..DATA_SIZE_WORDS-1 counter with clear, enable and terminal-count outputs; all other logic stays in fill_mem_responder.

Verification
REQ-035 Read at address=0x0100 with SRAM preloaded word k = 0x00_0100+k: mem_re for 64 cycles over 0x0100..0x013F, req_done in cycle 66, read_data word 63 = 0x00013F.
REQ-036 Write at address=0x0200 with word i = 0xA5_0000+i: 64 mem_we cycles, SRAM 0x0200+i holds 0xA50000+i, req_done in cycle 65, read_data unchanged.
REQ-037 read_enable=write_enable=1 in IDLE: req_err for one cycle; no mem_re or mem_we; busy stays 0.
REQ-038 Read at address=0xFFF0: mem_addr runs 0xFFF0..0xFFFF, then 0x0000..0x002F.
REQ-039 Assert n_rst at word 20 of a write: strobes low the next cycle, no req_done, all outputs at reset values, and a following read completes normally.
REQ-040 Pulse read_enable mid-write: it is ignored, and the write completes with unchanged address and data.
